// File: rtl/arcade_input_map.sv
// arcade_input_map: merges PS/2 key events and joystick words into registered
// per-player direction/button/start/coin outputs. Optional autofire: ARCADE_AUTOFIRE_EN.
module arcade_input_map #(
  parameter int unsigned PLAYERS      = 2,
  parameter int unsigned BUTTONS      = 3,
  parameter int unsigned COIN_PULSE   = 16,
  parameter int unsigned AUTOFIRE_DIV = 65536
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic [10:0]                ps2_key,
  input  logic [16*PLAYERS-1:0]      joystick,
  input  logic                       rotate,
  input  logic                       coin_from_start,
  input  logic [PLAYERS-1:0]         autofire,
  output logic [4*PLAYERS-1:0]       dir_out,
  output logic [BUTTONS*PLAYERS-1:0] btn_out,
  output logic [PLAYERS-1:0]         start_out,
  output logic [PLAYERS-1:0]         coin_out
);

  localparam int unsigned CNT_W = $clog2(COIN_PULSE + 1);

  typedef enum logic [2:0] {K_NONE, K_DIR, K_BTN, K_START, K_COIN} key_kind_e;

  typedef struct packed {
    key_kind_e  kind;
    logic [1:0] player;
    logic [1:0] idx;
  } key_hit_t;

  // Direction idx follows the joystick bit order: 0 right, 1 left, 2 down, 3 up.
  function automatic key_hit_t decode_key(input logic ext, input logic [7:0] code);
    key_hit_t h;
    h = '{K_NONE, 2'd0, 2'd0};
    case (code)
      8'h75: h = '{K_DIR, 2'd0, 2'd3};
      8'h72: h = '{K_DIR, 2'd0, 2'd2};
      8'h6b: h = '{K_DIR, 2'd0, 2'd1};
      8'h74: h = '{K_DIR, 2'd0, 2'd0};
      default: begin
        if (!ext) begin
          case (code)
            8'h14, 8'h29: h = '{K_BTN, 2'd0, 2'd0};
            8'h11:        h = '{K_BTN, 2'd0, 2'd1};
            8'h12:        h = '{K_BTN, 2'd0, 2'd2};
            8'h2d:        h = '{K_DIR, 2'd1, 2'd3};
            8'h2b:        h = '{K_DIR, 2'd1, 2'd2};
            8'h23:        h = '{K_DIR, 2'd1, 2'd1};
            8'h34:        h = '{K_DIR, 2'd1, 2'd0};
            8'h1c:        h = '{K_BTN, 2'd1, 2'd0};
            8'h1b:        h = '{K_BTN, 2'd1, 2'd1};
            8'h15:        h = '{K_BTN, 2'd1, 2'd2};
            8'h16, 8'h05: h = '{K_START, 2'd0, 2'd0};
            8'h1e, 8'h06: h = '{K_START, 2'd1, 2'd0};
            8'h26:        h = '{K_START, 2'd2, 2'd0};
            8'h25:        h = '{K_START, 2'd3, 2'd0};
            8'h2e:        h = '{K_COIN, 2'd0, 2'd0};
            8'h36:        h = '{K_COIN, 2'd1, 2'd0};
            8'h3d:        h = '{K_COIN, 2'd2, 2'd0};
            8'h3e:        h = '{K_COIN, 2'd3, 2'd0};
            default:      ;
          endcase
        end
      end
    endcase
    return h;
  endfunction

  logic       valid_q, valid_d;
  logic       prev_tog_q, prev_tog_d;
  logic       key_event;
  key_hit_t   hit;
  logic [3:0] idx_oh;

  always_comb begin
    valid_d    = 1'b1;
    prev_tog_d = ps2_key[10];
    key_event  = valid_q & (ps2_key[10] ^ prev_tog_q);
    hit        = decode_key(ps2_key[8], ps2_key[7:0]);
    idx_oh     = 4'b0001 << hit.idx;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      prev_tog_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      prev_tog_q <= prev_tog_d;
    end
  end

`ifdef ARCADE_AUTOFIRE_EN
  localparam int unsigned AF_W = $clog2(AUTOFIRE_DIV);
  logic unused_inputs;
  assign unused_inputs = ^joystick;
`else
  logic unused_inputs;
  assign unused_inputs = ^{joystick, autofire, (AUTOFIRE_DIV > 1)};
`endif

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [3:0]         key_dir_q, key_dir_d, raw_dir, dir_q, dir_d;
    logic [BUTTONS-1:0] key_btn_q, key_btn_d, raw_btn, btn_q, btn_d;
    logic               key_start_q, key_start_d, key_coin_q, key_coin_d;
    logic               raw_start, start_q, start_d;
    logic               coin_req, req_prev_q, req_prev_d, coin_out_q, coin_out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel;
`ifdef ARCADE_AUTOFIRE_EN
    logic [AF_W-1:0]    af_cnt_q, af_cnt_d;
    logic               af_ph_q, af_ph_d, af_prev_q, af_prev_d;
`endif

    assign sel = key_event && (hit.player == 2'(p));

    // Button masks are cut to BUTTONS bits, so keys for absent buttons fall away.
    always_comb begin
      key_dir_d   = key_dir_q;
      key_btn_d   = key_btn_q;
      key_start_d = key_start_q;
      key_coin_d  = key_coin_q;
      if (sel) begin
        case (hit.kind)
          K_DIR:   key_dir_d = (key_dir_q & ~idx_oh) | (idx_oh & {4{ps2_key[9]}});
          K_BTN:   key_btn_d = (key_btn_q & ~idx_oh[BUTTONS-1:0]) |
                               (idx_oh[BUTTONS-1:0] & {BUTTONS{ps2_key[9]}});
          K_START: key_start_d = ps2_key[9];
          K_COIN:  key_coin_d  = ps2_key[9];
          default: ;
        endcase
      end
    end

    always_comb begin
      raw_dir    = key_dir_q | joystick[16*p +: 4];
      raw_btn    = key_btn_q | joystick[16*p+4 +: BUTTONS];
      raw_start  = key_start_q | joystick[16*p+7];
      coin_req   = key_coin_q | joystick[16*p+8] | (coin_from_start & raw_start);
      dir_d      = rotate ? {raw_dir[1], raw_dir[0], raw_dir[2], raw_dir[3]} : raw_dir;
      btn_d      = raw_btn;
      start_d    = raw_start;
      req_prev_d = coin_req;
      coin_out_d = (cnt_q != '0);
      // Edge detect is gated by valid so a request held through reset never fires.
      if (valid_q && coin_req && !req_prev_q && cnt_q == '0) cnt_d = CNT_W'(COIN_PULSE);
      else if (cnt_q != '0)                                   cnt_d = cnt_q - CNT_W'(1);
      else                                                    cnt_d = cnt_q;
`ifdef ARCADE_AUTOFIRE_EN
      af_cnt_d  = af_cnt_q;
      af_ph_d   = af_ph_q;
      af_prev_d = raw_btn[0];
      if (raw_btn[0] && !af_prev_q) begin
        af_cnt_d = '0;
        af_ph_d  = 1'b1;
      end else if (raw_btn[0]) begin
        if (af_cnt_q == AF_W'(AUTOFIRE_DIV - 1)) begin
          af_cnt_d = '0;
          af_ph_d  = ~af_ph_q;
        end else begin
          af_cnt_d = af_cnt_q + AF_W'(1);
        end
      end
      if (autofire[p]) btn_d[0] = raw_btn[0] & af_ph_d;
`endif
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        key_dir_q   <= '0;
        key_btn_q   <= '0;
        key_start_q <= 1'b0;
        key_coin_q  <= 1'b0;
        dir_q       <= '0;
        btn_q       <= '0;
        start_q     <= 1'b0;
        req_prev_q  <= 1'b0;
        coin_out_q  <= 1'b0;
        cnt_q       <= '0;
`ifdef ARCADE_AUTOFIRE_EN
        af_cnt_q    <= '0;
        af_ph_q     <= 1'b0;
        af_prev_q   <= 1'b0;
`endif
      end else begin
        key_dir_q   <= key_dir_d;
        key_btn_q   <= key_btn_d;
        key_start_q <= key_start_d;
        key_coin_q  <= key_coin_d;
        dir_q       <= dir_d;
        btn_q       <= btn_d;
        start_q     <= start_d;
        req_prev_q  <= req_prev_d;
        coin_out_q  <= coin_out_d;
        cnt_q       <= cnt_d;
`ifdef ARCADE_AUTOFIRE_EN
        af_cnt_q    <= af_cnt_d;
        af_ph_q     <= af_ph_d;
        af_prev_q   <= af_prev_d;
`endif
      end
    end

    assign dir_out[4*p +: 4]             = dir_q;
    assign btn_out[BUTTONS*p +: BUTTONS] = btn_q;
    assign start_out[p]                  = start_q;
    assign coin_out[p]                   = coin_out_q;
  end

endmodule

// File: tb/tb_arcade_input_map.sv
// Testbench for arcade_input_map: joystick vector table plus directed keyboard,
// coin-pulse, reset, multi-player, PLAYERS=1 and autofire sequences.
module tb_arcade_input_map;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [10:0] ps2_key;
  logic [31:0] joy;
  logic [15:0] joy1;
  logic        rotate, cfs;
  logic [1:0]  af;
  logic [0:0]  af1;
  logic [7:0]  dir_out;
  logic [5:0]  btn_out;
  logic [1:0]  start_out, coin_out;
  logic [3:0]  p1_dir;
  logic [2:0]  p1_btn;
  logic [0:0]  p1_start, p1_coin;

  int errors = 0;
  int checks = 0;

  arcade_input_map #(.PLAYERS(2), .BUTTONS(3), .COIN_PULSE(16), .AUTOFIRE_DIV(4)) u_dut (
    .clk_sys(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joy),
    .rotate(rotate), .coin_from_start(cfs), .autofire(af),
    .dir_out(dir_out), .btn_out(btn_out), .start_out(start_out), .coin_out(coin_out)
  );

  arcade_input_map #(.PLAYERS(1), .BUTTONS(3), .COIN_PULSE(16), .AUTOFIRE_DIV(4)) u_p1 (
    .clk_sys(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joy1),
    .rotate(rotate), .coin_from_start(cfs), .autofire(af1),
    .dir_out(p1_dir), .btn_out(p1_btn), .start_out(p1_start), .coin_out(p1_coin)
  );

  typedef struct {
    string       name;
    logic [31:0] joy;
    logic        rot;
    logic [7:0]  dir;
    logic [5:0]  btn;
    logic [1:0]  start;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_b;
    logic [1:0] exp_c;

    vecs[0]  = '{"idle",       32'h0000_0000, 1'b0, 8'h00, 6'h00, 2'b00};
    vecs[1]  = '{"p0_right",   32'h0000_0001, 1'b0, 8'h01, 6'h00, 2'b00};
    vecs[2]  = '{"p0_up",      32'h0000_0008, 1'b0, 8'h08, 6'h00, 2'b00};
    vecs[3]  = '{"rot_up",     32'h0000_0008, 1'b1, 8'h01, 6'h00, 2'b00};
    vecs[4]  = '{"rot_left",   32'h0000_0002, 1'b1, 8'h08, 6'h00, 2'b00};
    vecs[5]  = '{"rot_right",  32'h0000_0001, 1'b1, 8'h04, 6'h00, 2'b00};
    vecs[6]  = '{"rot_down",   32'h0000_0004, 1'b1, 8'h02, 6'h00, 2'b00};
    vecs[7]  = '{"p0_btns",    32'h0000_0070, 1'b0, 8'h00, 6'h07, 2'b00};
    vecs[8]  = '{"p0_start",   32'h0000_0080, 1'b0, 8'h00, 6'h00, 2'b01};
    vecs[9]  = '{"p1_btn1_st", 32'h00A0_0000, 1'b0, 8'h00, 6'h10, 2'b10};
    vecs[10] = '{"all_dirs",   32'h000F_000F, 1'b1, 8'hFF, 6'h00, 2'b00};
    vecs[11] = '{"unused_hi",  32'h0000_FE00, 1'b0, 8'h00, 6'h00, 2'b00};
    vecs[12] = '{"p1_rot_ur",  32'h0009_0000, 1'b1, 8'h50, 6'h00, 2'b00};

    reset_n = 1'b0;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h16};
    joy = '0; joy1 = '0; rotate = 1'b0; cfs = 1'b0; af = '0; af1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {dir_out, btn_out, start_out, coin_out}, 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_reset_main", {dir_out, btn_out, start_out, coin_out}, 32'h0);
      check("post_reset_p1", {p1_dir, p1_btn, p1_start, p1_coin}, 32'h0);
    end

    for (int i = 0; i < 13; i++) begin
      joy = vecs[i].joy;
      rotate = vecs[i].rot;
      tick();
      check({vecs[i].name, "/dir"}, dir_out, vecs[i].dir);
      check({vecs[i].name, "/btn"}, btn_out, vecs[i].btn);
      check({vecs[i].name, "/start"}, start_out, vecs[i].start);
      check({vecs[i].name, "/coin"}, coin_out, 2'b00);
    end
    joy = '0; rotate = 1'b0;
    tick();

    send_key(1'b1, 1'b1, 8'h75);
    tick(); check("key_up_lat1", dir_out, 8'h00);
    tick(); check("key_up_press", dir_out, 8'h08);
    send_key(1'b0, 1'b1, 8'h75);
    tick(); tick(); check("key_up_release", dir_out, 8'h00);

    rotate = 1'b1;
    send_key(1'b1, 1'b0, 8'h6B);
    tick(); tick(); check("key_left_rotated", dir_out, 8'h08);
    send_key(1'b0, 1'b0, 8'h6B);
    rotate = 1'b0;
    tick(); tick(); check("key_left_release", dir_out, 8'h00);

    send_key(1'b1, 1'b1, 8'h14);
    tick(); tick(); check("ext_nonarrow_ignored", btn_out, 6'h00);
    send_key(1'b1, 1'b0, 8'h29);
    tick(); tick(); check("key_btn0_alias", btn_out, 6'h01);
    send_key(1'b0, 1'b0, 8'h29);
    tick(); tick(); check("key_btn0_release", btn_out, 6'h00);
    send_key(1'b1, 1'b0, 8'h05);
    tick(); tick(); check("key_f1_start0", start_out, 2'b01);
    send_key(1'b0, 1'b0, 8'h05);
    tick(); tick(); check("key_f1_release", start_out, 2'b00);

    send_key(1'b1, 1'b0, 8'h2E);
    tick(); tick(); check("key_coin_lat2", coin_out, 2'b00);
    tick(); check("key_coin_lat3", coin_out, 2'b01);
    repeat (20) tick();
    check("key_coin_done", coin_out, 2'b00);
    send_key(1'b0, 1'b0, 8'h2E);
    tick(); tick();

    joy[8] = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      exp_c = {1'b0, (i >= 2 && i <= 17)};
      check("coin_hold", coin_out, exp_c);
      if (i == 8)  joy[8] = 1'b0;
      if (i == 10) joy[8] = 1'b1;
    end

    joy[8] = 1'b0;
    repeat (3) tick();
    joy[8] = 1'b1;
    repeat (5) tick();
    check("coin_before_reset", coin_out, 2'b01);
    reset_n = 1'b0;
    #1;
    check("reset_mid_pulse", {dir_out, btn_out, start_out, coin_out}, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      check("held_coin_after_reset", coin_out, 2'b00);
    end
    joy[8] = 1'b0;
    repeat (3) tick();

    cfs = 1'b1;
    send_key(1'b1, 1'b0, 8'h1E);
    joy[8] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      exp_c = {(i >= 3 && i <= 18), (i >= 2 && i <= 17)};
      check("coin_concurrent", coin_out, exp_c);
      check("start_from_key", start_out, (i >= 2) ? 2'b10 : 2'b00);
    end
    joy[8] = 1'b0;
    cfs = 1'b0;
    send_key(1'b0, 1'b0, 8'h1E);
    repeat (3) tick();

    send_key(1'b1, 1'b0, 8'h34);
    tick(); tick();
    check("p1only_key034", {p1_dir, p1_btn, p1_start, p1_coin}, 32'h0);
    check("main_key034", dir_out, 8'h10);
    send_key(1'b1, 1'b0, 8'h1E);
    tick(); tick();
    check("p1only_key01e", {p1_dir, p1_btn, p1_start, p1_coin}, 32'h0);
    check("main_key01e", start_out, 2'b10);
    send_key(1'b0, 1'b0, 8'h34);
    tick(); tick();
    send_key(1'b0, 1'b0, 8'h1E);
    tick(); tick();
    send_key(1'b1, 1'b0, 8'h16);
    tick(); tick();
    check("p1only_start0", p1_start, 1'b1);
    send_key(1'b0, 1'b0, 8'h16);
    tick(); tick();
    joy1 = 16'h0010;
    tick();
    check("p1only_joy_btn0", p1_btn, 3'b001);
    joy1 = '0;
    tick();

    af = 2'b01;
    joy = 32'h0000_0010;
    for (int i = 1; i <= 20; i++) begin
      tick();
`ifdef ARCADE_AUTOFIRE_EN
      exp_b = (((i - 1) / 4) % 2) == 0;
`else
      exp_b = 1'b1;
`endif
      check("autofire_btn0", btn_out[0], exp_b);
    end
    joy = '0;
    tick();
    check("autofire_release", btn_out, 6'h00);
    af = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
